// File: rtl/eth_pkg.sv
// Shared Ethernet constants and receive FSM state type.
// Used by the GMII receive framer and the transmit path.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 step, one byte, reflected, LSB first.
// Shared by the receive framer and the transmit path.
import eth_pkg::*;

module crc32_d8 (
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = {1'b0, c[31:1]} ^ (ETH_CRC_POLY & {32{c[0] ^ data[i]}});
    end
  end

  assign crc_next = c;

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks CRC-32,
// withholds FCS, reports per-frame status and frame counters.
import eth_pkg::*;

module gmii_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        done,
  output logic        done_good,
  output logic [10:0] done_len,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);

  localparam logic [10:0] LEN_SAT = 11'h7FF;

  rx_state_t       state;
  rx_state_t       nstate;
  logic [31:0]     crc;
  logic [31:0]     crc_nxt;
  logic [10:0]     len;
  logic [3:0][7:0] dly;
  logic            sfd;
  logic            take;
  logic            eof;
  logic            frame_ok;

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (rx_data),
    .crc_next (crc_nxt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (rx_dv)
          nstate = (rx_data == ETH_PREAMBLE) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!rx_dv)                       nstate = IDLE;
        else if (rx_data == ETH_SFD)      nstate = DATA;
        else if (rx_data != ETH_PREAMBLE) nstate = DROP;
      end
      DATA: if (!rx_dv) nstate = IDLE;
      DROP: if (!rx_dv) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign sfd  = (state == PREAMBLE) && rx_dv &&
                (rx_data == ETH_SFD);
  assign take = (state == DATA) && rx_dv;
  assign eof  = (state == DATA) && !rx_dv;

  assign frame_ok = (crc == ETH_CRC_RESIDUE) &&
                    (len >= 11'(MIN_LEN)) &&
                    (len <= 11'(MAX_LEN));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc        <= '0;
      len        <= '0;
      dly        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      done       <= 1'b0;
      done_good  <= 1'b0;
      done_len   <= '0;
      good_count <= '0;
      bad_count  <= '0;
    end else begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      done      <= 1'b0;
      done_good <= 1'b0;
      done_len  <= '0;
      if (sfd) begin
        crc <= ETH_CRC_INIT;
        len <= '0;
      end
      if (take) begin
        crc <= crc_nxt;
        dly <= {dly[2:0], rx_data};
        if (len != LEN_SAT) len <= len + 11'd1;
        // oldest byte leaves once 4 newer bytes are behind it
        if (len >= 11'd4) begin
          out_valid <= 1'b1;
          out_data  <= dly[3];
          out_sof   <= (len == 11'd4);
        end
      end
      if (eof) begin
        done      <= 1'b1;
        done_good <= frame_ok;
        done_len  <= len;
        if (frame_ok) begin
          if (good_count != 16'hFFFF) good_count <= good_count + 16'd1;
        end else begin
          if (bad_count != 16'hFFFF) bad_count <= bad_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed plus randomized frames against a byte-level model.
module tb_gmii_rx_framer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        done;
  logic        done_good;
  logic [10:0] done_len;
  logic [15:0] good_count;
  logic [15:0] bad_count;

  gmii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_dv      (rx_dv),
    .rx_data    (rx_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .done       (done),
    .done_good  (done_good),
    .done_len   (done_len),
    .good_count (good_count),
    .bad_count  (bad_count)
  );

  always #4 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] frm[$];
  logic [7:0] got[$];
  int sof_idx[$];
  int sof_bad, vrise, done_cnt, ov_in_done, nz_status;
  int sof_cyc, done_cyc, b4_cyc, dv0_cyc;
  logic last_good;
  logic [10:0] last_len;
  logic prev_v = 1'b0;
  logic [15:0] mg = 0;
  logic [15:0] mb = 0;

  always @(negedge clock) begin
    if (out_valid) begin
      if (out_sof) begin
        sof_idx.push_back(got.size());
        sof_cyc = cyc;
      end
      if (!prev_v) vrise++;
      got.push_back(out_data);
    end else if (out_sof) sof_bad++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      last_good = done_good;
      last_len = done_len;
      if (out_valid) ov_in_done++;
    end else if (done_good || done_len != 0) nz_status++;
    prev_v = out_valid;
  end

  task automatic clr();
    got.delete();
    sof_idx.delete();
    sof_bad = 0; vrise = 0; done_cnt = 0;
    ov_in_done = 0; nz_status = 0;
    sof_cyc = -1; done_cyc = -1; b4_cyc = -1; dv0_cyc = -1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Standard Ethernet FCS: reflected CRC-32, final complement
  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, frm[i]};
      for (int j = 0; j < 8; j++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcs_ok();
    int n = frm.size();
    if (n < 4) return 1'b0;
    return {frm[n-1], frm[n-2], frm[n-3], frm[n-4]} == crc_of(n - 4);
  endfunction

  task automatic build(input int plen);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
    c = crc_of(plen);
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic drv(input logic v, input logic [7:0] d);
    @(negedge clock);
    rx_dv = v;
    rx_data = d;
  endtask

  task automatic tx(input int npre, input int rst_at);
    clr();
    for (int i = 0; i < npre; i++) drv(1'b1, 8'h55);
    drv(1'b1, 8'hD5);
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clock);
      if (i == 4) b4_cyc = cyc;
      reset = (i == rst_at);
      rx_dv = 1'b1;
      rx_data = frm[i];
      if (i == rst_at) begin
        #1;
        check("rst.out_valid", 32'(out_valid), 0);
        check("rst.out_data", 32'(out_data), 0);
        check("rst.done", 32'(done), 0);
        check("rst.good_count", 32'(good_count), 0);
        check("rst.bad_count", 32'(bad_count), 0);
        mg = 0;
        mb = 0;
        clr();
      end
    end
    @(negedge clock);
    reset = 1'b0;
    rx_dv = 1'b0;
    rx_data = 8'h00;
    dv0_cyc = cyc;
    repeat (4) @(negedge clock);
  endtask

  task automatic chk_frame(input string t);
    int n = frm.size();
    int no = (n >= 5) ? n - 4 : 0;
    bit g = fcs_ok() && n >= 64 && n <= 1518;
    int mism = 0;
    if (g) mg = (mg == 16'hFFFF) ? mg : mg + 1;
    else   mb = (mb == 16'hFFFF) ? mb : mb + 1;
    for (int i = 0; i < got.size() && i < no; i++)
      if (got[i] !== frm[i]) mism++;
    check({t, ".nout"}, 32'(got.size()), 32'(no));
    check({t, ".data"}, 32'(mism), 0);
    check({t, ".nsof"}, 32'(sof_idx.size()), 32'(no > 0));
    if (no > 0 && sof_idx.size() > 0) begin
      check({t, ".sofpos"}, 32'(sof_idx[0]), 0);
      check({t, ".lat"}, 32'(sof_cyc), 32'(b4_cyc + 1));
    end
    check({t, ".contig"}, 32'(vrise), 32'(no > 0));
    check({t, ".sofstray"}, 32'(sof_bad), 0);
    check({t, ".ndone"}, 32'(done_cnt), 1);
    check({t, ".donelat"}, 32'(done_cyc), 32'(dv0_cyc + 1));
    check({t, ".len"}, 32'(last_len), 32'((n > 2047) ? 2047 : n));
    check({t, ".good"}, 32'(last_good), 32'(g));
    check({t, ".ov_done"}, 32'(ov_in_done), 0);
    check({t, ".status_idle"}, 32'(nz_status), 0);
    check({t, ".good_count"}, 32'(good_count), 32'(mg));
    check({t, ".bad_count"}, 32'(bad_count), 32'(mb));
  endtask

  task automatic chk_silent(input string t);
    check({t, ".nout"}, 32'(got.size()), 0);
    check({t, ".ndone"}, 32'(done_cnt), 0);
    check({t, ".good_count"}, 32'(good_count), 32'(mg));
    check({t, ".bad_count"}, 32'(bad_count), 32'(mb));
  endtask

  initial begin
    clr();
    repeat (3) @(negedge clock);
    check("reset.out_valid", 32'(out_valid), 0);
    check("reset.out_sof", 32'(out_sof), 0);
    check("reset.out_data", 32'(out_data), 0);
    check("reset.done", 32'(done), 0);
    check("reset.done_good", 32'(done_good), 0);
    check("reset.done_len", 32'(done_len), 0);
    check("reset.good_count", 32'(good_count), 0);
    check("reset.bad_count", 32'(bad_count), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    build(60); tx(7, -1); chk_frame("good64");
    build(60); frm[10] ^= 8'h01; tx(7, -1); chk_frame("crcbad");

    clr();
    drv(1'b1, 8'h55); drv(1'b1, 8'h55); drv(1'b1, 8'hAA);
    for (int i = 0; i < 67; i++) drv(1'b1, 8'($urandom));
    drv(1'b0, 8'h00);
    repeat (4) @(negedge clock);
    chk_silent("drop");

    clr();
    drv(1'b1, 8'h55); drv(1'b1, 8'h55); drv(1'b1, 8'h55);
    drv(1'b0, 8'h00);
    repeat (4) @(negedge clock);
    chk_silent("pre_abort");

    clr();
    drv(1'b1, 8'hD5);
    for (int i = 0; i < 10; i++) drv(1'b1, 8'($urandom));
    drv(1'b0, 8'h00);
    repeat (4) @(negedge clock);
    chk_silent("idle_sfd");

    build(59); tx(7, -1); chk_frame("len63");
    frm.delete();
    frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
    tx(7, -1); chk_frame("len2");

    build(1515); tx(7, -1); chk_frame("len1519");
    build(1514); tx(7, -1); chk_frame("len1518");
    build(2096); tx(7, -1); chk_frame("lensat");

    for (int k = 0; k < 8; k++) begin
      build($urandom_range(0, 80));
      if ($urandom_range(0, 1) == 1)
        frm[$urandom_range(0, frm.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
      tx($urandom_range(1, 7), -1);
      chk_frame($sformatf("rnd%0d", k));
    end
    for (int k = 0; k < 3; k++) begin
      frm.delete();
      for (int i = 0; i < int'($urandom_range(1, 4)); i++)
        frm.push_back(8'($urandom));
      tx(7, -1);
      chk_frame($sformatf("short%0d", k));
    end

    build(60);
    if (frm[21] == 8'h55) frm[21] = 8'h56;
    tx(7, 20);
    chk_silent("rst_mid");
    build(60); tx(7, -1); chk_frame("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
